// File: rtl/note_pkg.sv
// Shared constants for the harmonic step generator: octave-1 step table and FSM states.
package note_pkg;
    localparam int DEF_INT_W  = 10;
    localparam int DEF_FRAC_W = 10;
    localparam int DEF_STEP_W = DEF_INT_W + DEF_FRAC_W;
    localparam int SEMIS      = 12;
    localparam int BASE_W     = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // Octave-1 Q10.10 steps, A through G#.
    function automatic logic [BASE_W-1:0] base_tbl(input logic [3:0] r);
        case (r)
            4'd0:    return 15'd9611;
            4'd1:    return 15'd10179;
            4'd2:    return 15'd10813;
            4'd3:    return 15'd11446;
            4'd4:    return 15'd12102;
            4'd5:    return 15'd12845;
            4'd6:    return 15'd13587;
            4'd7:    return 15'd14417;
            4'd8:    return 15'd15248;
            4'd9:    return 15'd16165;
            4'd10:   return 15'd17126;
            4'd11:   return 15'd18131;
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/note_divmod12.sv
// Sequential subtract-12 divider: splits (note-1) into semitone and octave, one step per cycle.
module note_divmod12
    import note_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] note,
    output logic [ADDR_W-1:0] rem,
    output logic [ADDR_W-1:0] oct,
    output logic              done
);
    logic run;

    assign done = run && (int'(rem) < SEMIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            oct <= '0;
            run <= 1'b0;
        end else if (start) begin
            rem <= note - ADDR_W'(1);
            oct <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (int'(rem) >= SEMIS) begin
                rem <= rem - ADDR_W'(SEMIS);
                oct <= oct + ADDR_W'(1);
            end else begin
                run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/harmonic_step_gen.sv
// Streams the fundamental and harmonic phase steps for one note, one beat per output handshake.
module harmonic_step_gen
    import note_pkg::*;
#(
    parameter int INT_W  = 10,
    parameter int FRAC_W = 10,
    parameter int N_HARM = 4,
    parameter int ADDR_W = 6,
    parameter logic [INT_W+FRAC_W:0] MAX_STEP = {1'b0, {(INT_W+FRAC_W){1'b1}}},
    localparam int STEP_W = INT_W + FRAC_W,
    localparam int IW     = (N_HARM > 1) ? $clog2(N_HARM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_note,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STEP_W-1:0] out_step,
    output logic [IW-1:0]     out_idx,
    output logic              out_last,
    output logic              busy
);
    localparam int ACC_W = STEP_W + 1;
    localparam int WW    = ACC_W + BASE_W;
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(N_HARM - 1);

    logic [1:0]        state;
    logic [ACC_W-1:0]  acc, base;
    logic              ovf;
    logic [ADDR_W-1:0] dv_rem, dv_oct;
    logic              dv_done, dv_start;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign dv_start  = req_ready && req_valid && (req_note != '0);

    note_divmod12 #(.ADDR_W(ADDR_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dv_start),
        .note  (req_note),
        .rem   (dv_rem),
        .oct   (dv_oct),
        .done  (dv_done)
    );

    // Octave-scaled base, saturated so a huge shift cannot wrap under MAX_STEP.
    logic [WW-1:0]    shifted;
    logic [ACC_W-1:0] nb;
    always_comb begin
        shifted = WW'(base_tbl(4'(dv_rem))) << dv_oct;
        if (int'(dv_oct) >= ACC_W || shifted > WW'(ACC_MAX))
            nb = ACC_MAX;
        else
            nb = shifted[ACC_W-1:0];
    end

    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] nacc;
    logic             novf;
    always_comb begin
        sum_w = {1'b0, acc} + {1'b0, base};
        nacc  = sum_w[ACC_W] ? ACC_MAX : sum_w[ACC_W-1:0];
        novf  = ovf || (nacc > MAX_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            base      <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_step  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    if (req_note == '0) begin
                        state     <= ST_EMIT;
                        acc       <= '0;
                        base      <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        out_step  <= '0;
                        out_idx   <= '0;
                        out_last  <= (LAST_IDX == '0);
                    end else begin
                        state <= ST_DIV;
                    end
                end
                ST_DIV: if (dv_done) begin
                    state     <= ST_EMIT;
                    base      <= nb;
                    acc       <= nb;
                    ovf       <= (nb > MAX_STEP);
                    out_valid <= 1'b1;
                    out_step  <= (nb > MAX_STEP) ? '0 : nb[STEP_W-1:0];
                    out_idx   <= '0;
                    out_last  <= (LAST_IDX == '0);
                end
                ST_EMIT: if (out_ready) begin
                    if (out_last) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        acc      <= nacc;
                        ovf      <= novf;
                        out_step <= novf ? '0 : nacc[STEP_W-1:0];
                        out_idx  <= out_idx + IW'(1);
                        out_last <= (out_idx + IW'(1) == LAST_IDX);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
